// File: rtl/lcd_phrase_writer_if.sv
// Start/status handshake, phrase ROM port and HD44780 write bus seen by the writer.
interface lcd_phrase_writer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  modport master (
    input  start, rom_data,
    output busy, done, rom_addr, lcd_data, lcd_rs, lcd_rw, lcd_e
  );

  modport slave (
    output start, rom_data,
    input  busy, done, rom_addr, lcd_data, lcd_rs, lcd_rw, lcd_e
  );
endinterface

// File: rtl/lcd_phrase_writer.sv
// Runs the HD44780 init sequence, then copies a 32-byte phrase ROM onto both LCD lines.
module lcd_phrase_writer #(
  parameter int unsigned E_PULSE_CYCLES      = 12,
  parameter int unsigned CMD_WAIT_CYCLES     = 2000,
  parameter int unsigned CLEAR_WAIT_CYCLES   = 82000,
  parameter int unsigned POWERON_WAIT_CYCLES = 750000
) (
  input  logic                clock,
  input  logic                reset_n,
  lcd_phrase_writer_if.master bus
);

  localparam int unsigned MAX_EW   = (E_PULSE_CYCLES > CMD_WAIT_CYCLES) ? E_PULSE_CYCLES : CMD_WAIT_CYCLES;
  localparam int unsigned MAX_CP   = (CLEAR_WAIT_CYCLES > POWERON_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES
                                                                               : POWERON_WAIT_CYCLES;
  localparam int unsigned MAX_CNT  = (MAX_EW > MAX_CP) ? MAX_EW : MAX_CP;
  localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);
  localparam int unsigned STEP_W   = 6;
  localparam int unsigned LAST_STEP  = 37;
  localparam int unsigned CLEAR_STEP = 3;

  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PON_LAST   = CNT_W'(POWERON_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POWERON, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [STEP_W-1:0]  step, step_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               init_done, init_done_nx;
  logic               armed;
  logic [CNT_W-1:0]   wait_last;

  logic [4:0] rom_addr_q, rom_addr_nx;
  logic [7:0] lcd_data_q, lcd_data_nx;
  logic       lcd_rs_q, lcd_rs_nx;
  logic       lcd_e_q, lcd_e_nx;
  logic       busy_q, busy_nx;
  logic       done_q, done_nx;

  // Steps 5..20 and 22..37 carry ROM characters; the rest are commands.
  function automatic logic is_char(input logic [STEP_W-1:0] s);
    return ((s >= 6'd5) && (s <= 6'd20)) || ((s >= 6'd22) && (s <= 6'd37));
  endfunction

  function automatic logic [4:0] char_addr(input logic [STEP_W-1:0] s);
    return (s <= 6'd20) ? 5'(s - 6'd5) : 5'(s - 6'd6);
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [STEP_W-1:0] s);
    logic [7:0] b;
    case (s)
      6'd0:    b = 8'h38;
      6'd1:    b = 8'h0C;
      6'd2:    b = 8'h06;
      6'd3:    b = 8'h01;
      6'd4:    b = 8'h80;
      default: b = 8'hC0;
    endcase
    return b;
  endfunction

  // State, sequencing counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      step       <= '0;
      cnt        <= '0;
      init_done  <= 1'b0;
      armed      <= 1'b0;
      rom_addr_q <= '0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_e_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      step       <= step_nx;
      cnt        <= cnt_nx;
      init_done  <= init_done_nx;
      armed      <= 1'b1;
      rom_addr_q <= rom_addr_nx;
      lcd_data_q <= lcd_data_nx;
      lcd_rs_q   <= lcd_rs_nx;
      lcd_e_q    <= lcd_e_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
    end
  end

  // Next state; the counter restarts from zero whenever the state changes.
  always_comb begin
    state_nx     = state;
    step_nx      = step;
    cnt_nx       = '0;
    init_done_nx = init_done;
    wait_last    = (step == STEP_W'(CLEAR_STEP)) ? CLEAR_LAST : CMD_LAST;
    case (state)
      S_IDLE: begin
        // armed blocks a start coinciding with the reset release edge
        if (bus.start && armed) begin
          step_nx  = '0;
          state_nx = init_done ? S_LOAD : S_POWERON;
        end
      end
      S_POWERON: begin
        if (cnt == PON_LAST) begin
          init_done_nx = 1'b1;
          state_nx     = S_LOAD;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_LOAD:  state_nx = S_SETUP;
      S_SETUP: state_nx = S_PULSE;
      S_PULSE: begin
        if (cnt == E_LAST) state_nx = S_HOLD;
        else               cnt_nx   = cnt + CNT_W'(1);
      end
      S_HOLD:  state_nx = S_WAIT;
      S_WAIT: begin
        if (cnt == wait_last) begin
          if (step == STEP_W'(LAST_STEP)) begin
            state_nx = S_DONE;
          end else begin
            step_nx  = step + STEP_W'(1);
            state_nx = S_LOAD;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next output values. The ROM answers during SETUP, so lcd_data is captured at
  // the end of SETUP and lcd_e trails PULSE by one cycle to give a full setup cycle.
  always_comb begin
    rom_addr_nx = rom_addr_q;
    lcd_data_nx = lcd_data_q;
    lcd_rs_nx   = lcd_rs_q;
    lcd_e_nx    = (state == S_PULSE);
    busy_nx     = (state_nx != S_IDLE) && (state_nx != S_DONE);
    done_nx     = (state_nx == S_DONE);
    if ((state_nx == S_LOAD) && is_char(step_nx)) begin
      rom_addr_nx = char_addr(step_nx);
    end
    if (state == S_SETUP) begin
      lcd_rs_nx   = is_char(step);
      lcd_data_nx = is_char(step) ? bus.rom_data : cmd_byte(step);
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.lcd_data = lcd_data_q;
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = lcd_e_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/lcd_phrase_writer.md
# lcd_phrase_writer

Sequencer that sits directly downstream of the 32-character phrase ROMs and drives a 16x2 HD44780-compatible character LCD in 8-bit write-only mode. On a start request it runs the LCD init command sequence. It then reads all 32 ROM bytes in order, writing bytes 0–15 to line 1 and bytes 16–31 to line 2, and generates the E strobe and inter-command delays. Which phrase ROM feeds `rom_data` is selected outside this block.

## Interface
- `E_PULSE_CYCLES`, 12: clock cycles `lcd_e` is held high per write (≥1).
- `CMD_WAIT_CYCLES`, 2000: idle cycles after every write except clear (≥1).
- `CLEAR_WAIT_CYCLES`, 82000: idle cycles after the clear-display command (≥1).
- `POWERON_WAIT_CYCLES`, 750000: delay before the first command after reset (≥1).

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to (re)write the display; ignored while `busy`=1.
- `rom_addr`  out  5  address to phrase ROM.
- `rom_data`  in  8  ROM byte; valid one cycle after `rom_addr` (registered ROM).
- `lcd_data`  out  8  LCD DB7..DB0.
- `lcd_rs`  out  1  0 = command, 1 = character.
- `lcd_rw`  out  1  tied 0 (write only).
- `lcd_e`  out  1  enable strobe.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse when the last write's wait completes.

## Operation
- Reset (async, immediate, including mid-sequence) sets all outputs to 0, the state to IDLE, the step to 0, and clears `init_done`. `lcd_e` falls in the same instant as the reset.
- The write list has 38 steps:
  - 0: 0x38, function set.
  - 1: 0x0C, display on.
  - 2: 0x06, entry mode.
  - 3: 0x01, clear.
  - 4: 0x80, line 1 address.
  - 5–20: characters from ROM address step−5.
  - 21: 0xC0, line 2 address.
  - 22–37: characters from ROM address step−6.
- `lcd_rs`=1 only on character steps.
- States:
  - IDLE: on `start`=1, set `busy`, step←0. Go to POWERON if `init_done`=0, else LOAD.
  - POWERON: count `POWERON_WAIT_CYCLES` cycles, set `init_done`, go to LOAD.
  - LOAD (1 cycle): drive `rom_addr` for character steps; `rom_addr` holds its last value on command steps.
  - SETUP (1 cycle): register `lcd_data` (`rom_data` on character steps, else the command constant) and `lcd_rs`. `lcd_e`=0.
  - PULSE: `lcd_e`=1 for exactly `E_PULSE_CYCLES` cycles. `lcd_data`/`lcd_rs` stable.
  - HOLD (1 cycle): `lcd_e`=0, data stable.
  - WAIT: `CLEAR_WAIT_CYCLES` cycles on step 3, else `CMD_WAIT_CYCLES`. Then step 37 → DONE; otherwise step+1 → LOAD.
  - DONE (1 cycle): `done`=1, `busy`=0 in the same cycle, go to IDLE.
- `lcd_data`/`lcd_rs` keep their last values in IDLE; they are not cleared after completion.
- A `start` asserted in any state other than IDLE is dropped, not queued.
- Counters are sized to hold the largest parameter and reload to 0 on every state entry; no wrap-around within a state.

## Timing
- Cycles per normal write: 1 + 1 + `E_PULSE_CYCLES` + 1 + `CMD_WAIT_CYCLES`. The clear write uses `CLEAR_WAIT_CYCLES` instead.
- Total cycles from the `start` edge to `done`:
  - (`POWERON_WAIT_CYCLES` if first run) + 38·(3+`E_PULSE_CYCLES`) + 37·`CMD_WAIT_CYCLES` + `CLEAR_WAIT_CYCLES` + 1.
- Data/RS setup to `lcd_e` rise is ≥1 cycle; hold after `lcd_e` fall is ≥1 cycle plus the wait.
- `start` in the same cycle as the `reset_n` deassertion edge is ignored.

## Test plan
Parameters for all scenarios: E=2, CMD=5, CLEAR=20, POWERON=10. The ROM model holds "DEFINIR SECUN:  " on bytes 0–15 and "P:XY  S:XY  A:XY" on bytes 16–31.

- Reset values: hold `reset_n`=0 → all outputs 0. Release → `busy`=0, `lcd_e`=0.
- First run: pulse `start` after reset → `done` pulses exactly 10+38·5+37·5+20+1 = 406 cycles later.
  - Observed `lcd_e` rising edges capture (rs, data): (0,0x38), (0,0x0C), (0,0x06), (0,0x01), (0,0x80), then 16 chars "DEFINIR SECUN:  " with rs=1, then (0,0xC0), then "P:XY  S:XY  A:XY".
- E pulse shape: every `lcd_e` high is exactly 2 cycles. `lcd_data` is constant from 1 cycle before the rise to 1 cycle after the fall. There are 38 pulses total.
- Second run: `start` after `done` → no POWERON. `done` arrives 396 cycles later with an identical capture list.
- Start while busy: pulse `start` at cycle 50 of a run → pulse count stays 38 and no second sequence follows.
- Reset mid-operation: drop `reset_n` while `lcd_e`=1 during step 10 → `lcd_e`, `busy`, `lcd_data` are 0 before the next clock edge. A subsequent `start` repeats POWERON and the full 38-write sequence.
